l15_resp_buffer: RTL and testbench
==================================

Name: l15_resp_buffer

Overview:
- Sits directly downstream of the L1.5 wrapper on the transducer side.
- Consumes the L1.5 response bus (`l15_transducer_*`) and returns `transducer_l15_req_ack`.
- Queues responses in a small FIFO so the core-side transducer can drain them with a valid/ready handshake.
- Decouples L1.5 response timing from core-side backpressure; preserves response order exactly.

Parameters:
- DEPTH, 4, number of response entries; power of two, >=2.
- DATA_WIDTH, 512, response data width; equals the L1.5 response data width for a 64-byte L1D line.
- TID_WIDTH, 1, thread-id width.
- INVAL_WIDTH, 51, packed invalidation info width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- l15_transducer_val  in  1  response valid from L1.5
- l15_transducer_returntype  in  4  response type
- l15_transducer_l2miss  in  1  L2 miss flag
- l15_transducer_error  in  2  error code
- l15_transducer_noncacheable  in  1  NC flag
- l15_transducer_atomic  in  1  atomic flag
- l15_transducer_threadid  in  TID_WIDTH  thread id
- l15_transducer_prefetch  in  1  prefetch flag
- l15_transducer_f4b  in  1  4-byte fetch flag
- l15_transducer_data  in  DATA_WIDTH  response data
- l15_transducer_inval_info  in  INVAL_WIDTH  packed invalidation fields: address, ways, all-way/cross/inval bits, blockinitstore
- transducer_l15_req_ack  out  1  response accepted
- resp_val  out  1  head entry valid
- resp_rdy  in  1  consumer accepts head
- resp_returntype  out  4  head field
- resp_flags  out  7  head {l2miss, error[1:0], noncacheable, atomic, prefetch, f4b}
- resp_threadid  out  TID_WIDTH  head field
- resp_data  out  DATA_WIDTH  head field
- resp_inval_info  out  INVAL_WIDTH  head field
- resp_count  out  log2(DEPTH)+1  current occupancy

Behaviour:
- Clock and reset:
  - Clock port is `clk`, reset port is `rst`.
  - One clock domain; reset is synchronous and active-high.
- Storage:
  - DEPTH-entry circular buffer.
  - Pointers `wr_ptr` and `rd_ptr`, each log2(DEPTH) bits, wrap modulo DEPTH.
  - `count` is 0..DEPTH.
  - full = (count==DEPTH); empty = (count==0).
- Acknowledge and push:
  - `transducer_l15_req_ack = l15_transducer_val & ~full`, purely combinational.
  - Push occurs on any clock edge where the ack is high.
  - Each cycle with val&ack counts as exactly one response. Val held high across back-to-back ack cycles means consecutive distinct responses.
- Full:
  - Ack stays 0 while full, even if a pop occurs in the same cycle. There is no rdy->ack combinational path.
  - L1.5 holds its response stable until acked.
- Output side:
  - First-word-fall-through: `resp_val = ~empty`; `resp_*` fields are driven from entry[rd_ptr].
  - Pop on `resp_val & resp_rdy`.
- Latency:
  - A push into an empty buffer makes `resp_val` high the following cycle. There is no same-cycle bypass.
  - Minimum latency is 1 cycle.
- Simultaneous push and pop (not full, not empty): count unchanged, both pointers advance.
- `resp_rdy` while empty: ignored, no state change.
- Head stability: head fields stay stable while `resp_val & ~resp_rdy`.
- Reset values:
  - count=0, pointers=0, `resp_val`=0, `resp_count`=0.
  - `transducer_l15_req_ack`=0 while `rst` is high.
  - Entry contents are don't-care and need not be reset.
- Reset mid-operation: all buffered responses are discarded. The first cycle after reset deasserts behaves as empty.

Optional Feature:
- Macro: `L15_RESP_BUFFER_STATS_EN`.
- With the macro defined, two extra outputs are added:
  - `stat_stall_cycles[15:0]`: increments every cycle `l15_transducer_val & full`; saturates at 16'hFFFF.
  - `stat_max_count[log2(DEPTH):0]`: high-water mark of `count`.
  - Both reset to 0.
- Without the macro: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, single response:
  - Stimulus: reset, then one response (returntype=4'h0, data=512'hA5..A5) with `resp_rdy`=1.
  - Required: ack high in cycle 0; `resp_val` high in cycle 1 with data A5..A5; count returns to 0 in cycle 2.
- Fill and stall:
  - Stimulus: `resp_rdy`=0, 5 back-to-back responses with threadid alternating 0/1.
  - Required: first 4 acked; 5th held with ack=0; `resp_count`=4.
  - Then `resp_rdy`=1 for 1 cycle: pop; next cycle the 5th is acked.
  - Output order: tid 0,1,0,1,0.
- Wrap-around:
  - Stimulus: 10 responses (data=index) with `resp_rdy` toggling 1/0 every cycle.
  - Required: outputs appear in order 0..9; no loss or duplication; pointers wrap twice.
- Simultaneous push/pop at count=2: count stays 2; head advances to the next entry.
- Reset mid-operation:
  - Stimulus: count=3, assert `rst` for 1 cycle.
  - Required: `resp_val`=0 and count=0 next cycle; stale entries never appear on the output.
- Stats (`L15_RESP_BUFFER_STATS_EN`):
  - Stimulus: fill to 4, hold val high with full for 7 cycles.
  - Required: `stat_stall_cycles`=7, `stat_max_count`=4.

Source files
------------

// File: rtl/l15_resp_buffer.sv
// Response FIFO between the L1.5 response bus and the core-side transducer.
// Optional statistics outputs are enabled with `define L15_RESP_BUFFER_STATS_EN.
module l15_resp_buffer #(
  parameter int DEPTH       = 4,
  parameter int DATA_WIDTH  = 512,
  parameter int TID_WIDTH   = 1,
  parameter int INVAL_WIDTH = 51
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     l15_transducer_val,
  input  logic [3:0]               l15_transducer_returntype,
  input  logic                     l15_transducer_l2miss,
  input  logic [1:0]               l15_transducer_error,
  input  logic                     l15_transducer_noncacheable,
  input  logic                     l15_transducer_atomic,
  input  logic [TID_WIDTH-1:0]     l15_transducer_threadid,
  input  logic                     l15_transducer_prefetch,
  input  logic                     l15_transducer_f4b,
  input  logic [DATA_WIDTH-1:0]    l15_transducer_data,
  input  logic [INVAL_WIDTH-1:0]   l15_transducer_inval_info,
  output logic                     transducer_l15_req_ack,
  output logic                     resp_val,
  input  logic                     resp_rdy,
  output logic [3:0]               resp_returntype,
  output logic [6:0]               resp_flags,
  output logic [TID_WIDTH-1:0]     resp_threadid,
  output logic [DATA_WIDTH-1:0]    resp_data,
  output logic [INVAL_WIDTH-1:0]   resp_inval_info,
  output logic [$clog2(DEPTH):0]   resp_count
`ifdef L15_RESP_BUFFER_STATS_EN
  ,
  output logic [15:0]              stat_stall_cycles,
  output logic [$clog2(DEPTH):0]   stat_max_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [3:0]             r_rtMem    [DEPTH];
  logic [6:0]             r_flagsMem [DEPTH];
  logic [TID_WIDTH-1:0]   r_tidMem   [DEPTH];
  logic [DATA_WIDTH-1:0]  r_dataMem  [DEPTH];
  logic [INVAL_WIDTH-1:0] r_invalMem [DEPTH];

  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic [CW-1:0] w_countNext;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);

  // Ack depends only on registered fullness, so a same-cycle pop never frees a slot.
  assign w_push = l15_transducer_val & ~w_full & ~rst;
  assign w_pop  = ~w_empty & resp_rdy & ~rst;

  assign transducer_l15_req_ack = w_push;

  always_comb begin
    w_countNext = r_count;
    case ({w_push, w_pop})
      2'b10:   w_countNext = r_count + CW'(1);
      2'b01:   w_countNext = r_count - CW'(1);
      default: w_countNext = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
      r_count <= w_countNext;
    end
  end

  // Entry storage is intentionally left unreset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_rtMem[r_wrPtr]    <= l15_transducer_returntype;
      r_flagsMem[r_wrPtr] <= {l15_transducer_l2miss, l15_transducer_error,
                              l15_transducer_noncacheable, l15_transducer_atomic,
                              l15_transducer_prefetch, l15_transducer_f4b};
      r_tidMem[r_wrPtr]   <= l15_transducer_threadid;
      r_dataMem[r_wrPtr]  <= l15_transducer_data;
      r_invalMem[r_wrPtr] <= l15_transducer_inval_info;
    end
  end

  assign resp_val        = ~w_empty;
  assign resp_returntype = r_rtMem[r_rdPtr];
  assign resp_flags      = r_flagsMem[r_rdPtr];
  assign resp_threadid   = r_tidMem[r_rdPtr];
  assign resp_data       = r_dataMem[r_rdPtr];
  assign resp_inval_info = r_invalMem[r_rdPtr];
  assign resp_count      = r_count;

`ifdef L15_RESP_BUFFER_STATS_EN
  logic [15:0]   r_stallCycles;
  logic [CW-1:0] r_maxCount;

  // Stall counter saturates; the high-water mark tracks the post-update occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCycles <= '0;
      r_maxCount    <= '0;
    end else begin
      if (l15_transducer_val && w_full && (r_stallCycles != 16'hFFFF))
        r_stallCycles <= r_stallCycles + 16'd1;
      if (w_countNext > r_maxCount)
        r_maxCount <= w_countNext;
    end
  end

  assign stat_stall_cycles = r_stallCycles;
  assign stat_max_count    = r_maxCount;
`endif

endmodule

// File: tb/tb_l15_resp_buffer.sv
// Self-checking bench for l15_resp_buffer against a queue-based response model.
// Stats checks are compiled in when L15_RESP_BUFFER_STATS_EN is defined.
module tb_l15_resp_buffer;

  localparam int DEPTH = 4;
  localparam int DW    = 512;
  localparam int TW    = 1;
  localparam int IW    = 51;
  localparam int CW    = 3;

  typedef struct packed {
    logic [3:0]    rt;
    logic [6:0]    flags;
    logic [TW-1:0] tid;
    logic [DW-1:0] data;
    logic [IW-1:0] inval;
  } resp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          l15_transducer_val;
  logic [3:0]    l15_transducer_returntype;
  logic          l15_transducer_l2miss;
  logic [1:0]    l15_transducer_error;
  logic          l15_transducer_noncacheable;
  logic          l15_transducer_atomic;
  logic [TW-1:0] l15_transducer_threadid;
  logic          l15_transducer_prefetch;
  logic          l15_transducer_f4b;
  logic [DW-1:0] l15_transducer_data;
  logic [IW-1:0] l15_transducer_inval_info;
  logic          transducer_l15_req_ack;
  logic          resp_val;
  logic          resp_rdy;
  logic [3:0]    resp_returntype;
  logic [6:0]    resp_flags;
  logic [TW-1:0] resp_threadid;
  logic [DW-1:0] resp_data;
  logic [IW-1:0] resp_inval_info;
  logic [CW-1:0] resp_count;
`ifdef L15_RESP_BUFFER_STATS_EN
  logic [15:0]   stat_stall_cycles;
  logic [CW-1:0] stat_max_count;
`endif

  always #5 clk = ~clk;

  l15_resp_buffer #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .TID_WIDTH(TW), .INVAL_WIDTH(IW)) dut (
    .clk                         (clk),
    .rst                         (rst),
    .l15_transducer_val          (l15_transducer_val),
    .l15_transducer_returntype   (l15_transducer_returntype),
    .l15_transducer_l2miss       (l15_transducer_l2miss),
    .l15_transducer_error        (l15_transducer_error),
    .l15_transducer_noncacheable (l15_transducer_noncacheable),
    .l15_transducer_atomic       (l15_transducer_atomic),
    .l15_transducer_threadid     (l15_transducer_threadid),
    .l15_transducer_prefetch     (l15_transducer_prefetch),
    .l15_transducer_f4b          (l15_transducer_f4b),
    .l15_transducer_data         (l15_transducer_data),
    .l15_transducer_inval_info   (l15_transducer_inval_info),
    .transducer_l15_req_ack      (transducer_l15_req_ack),
    .resp_val                    (resp_val),
    .resp_rdy                    (resp_rdy),
    .resp_returntype             (resp_returntype),
    .resp_flags                  (resp_flags),
    .resp_threadid               (resp_threadid),
    .resp_data                   (resp_data),
    .resp_inval_info             (resp_inval_info),
    .resp_count                  (resp_count)
`ifdef L15_RESP_BUFFER_STATS_EN
    ,
    .stat_stall_cycles           (stat_stall_cycles),
    .stat_max_count              (stat_max_count)
`endif
  );

  resp_t         q[$];
  logic [TW-1:0] tidLog[$];
  logic [DW-1:0] dataLog[$];
  int            total = 0;
  int            bad   = 0;
  int            modelStall = 0;
  int            modelMax   = 0;

  logic  curVal, curRdy, curRst;
  resp_t curResp;

  logic          lastAck, lastVal;
  logic [CW-1:0] lastCount;
  logic [DW-1:0] lastData;
`ifdef L15_RESP_BUFFER_STATS_EN
  logic [15:0]   lastStall;
  logic [CW-1:0] lastMax;
`endif

  task automatic checkEq(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic resp_t randResp();
    resp_t       r;
    logic [31:0] w;
    logic [63:0] iv;
    w       = $urandom();
    r.rt    = w[3:0];
    r.flags = w[10:4];
    r.tid   = w[11 +: TW];
    for (int i = 0; i < DW / 32; i++) r.data[i*32 +: 32] = $urandom();
    iv      = {$urandom(), $urandom()};
    r.inval = iv[IW-1:0];
    return r;
  endfunction

  task automatic applyStimulus(input logic v, input resp_t r, input logic rdy, input logic rs);
    curVal  = v;
    curRdy  = rdy;
    curRst  = rs;
    curResp = r;
    rst                         = rs;
    l15_transducer_val          = v;
    l15_transducer_returntype   = r.rt;
    l15_transducer_l2miss       = r.flags[6];
    l15_transducer_error        = r.flags[5:4];
    l15_transducer_noncacheable = r.flags[3];
    l15_transducer_atomic       = r.flags[2];
    l15_transducer_prefetch     = r.flags[1];
    l15_transducer_f4b          = r.flags[0];
    l15_transducer_threadid     = r.tid;
    l15_transducer_data         = r.data;
    l15_transducer_inval_info   = r.inval;
    resp_rdy                    = rdy;
  endtask

  // Samples mid-cycle and compares against the pre-edge model state.
  task automatic checkOutput();
    @(negedge clk);
    lastAck   = transducer_l15_req_ack;
    lastVal   = resp_val;
    lastCount = resp_count;
    lastData  = resp_data;
    checkEq("ack", transducer_l15_req_ack, !curRst && curVal && (q.size() < DEPTH));
    if (!curRst) begin
      checkEq("resp_val", resp_val, q.size() != 0);
      checkEq("resp_count", resp_count, q.size());
      if (q.size() != 0) begin
        checkEq("head_rt", resp_returntype, q[0].rt);
        checkEq("head_flags", resp_flags, q[0].flags);
        checkEq("head_tid", resp_threadid, q[0].tid);
        checkEq("head_data", resp_data, q[0].data);
        checkEq("head_inval", resp_inval_info, q[0].inval);
      end
      if (resp_val && curRdy) begin
        tidLog.push_back(resp_threadid);
        dataLog.push_back(resp_data);
      end
`ifdef L15_RESP_BUFFER_STATS_EN
      lastStall = stat_stall_cycles;
      lastMax   = stat_max_count;
      checkEq("stat_stall", stat_stall_cycles, modelStall);
      checkEq("stat_max", stat_max_count, modelMax);
`endif
    end
  endtask

  task automatic doCycle(input logic v, input resp_t r, input logic rdy, input logic rs,
                         output logic acked);
    applyStimulus(v, r, rdy, rs);
    checkOutput();
    acked = !rs && v && (q.size() < DEPTH);
    if (rs) begin
      q.delete();
      modelStall = 0;
      modelMax   = 0;
    end else begin
      if (v && q.size() == DEPTH && modelStall < 65535) modelStall++;
      if (rdy && q.size() > 0) void'(q.pop_front());
      if (acked) q.push_back(r);
      if (q.size() > modelMax) modelMax = q.size();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    resp_t r;
    resp_t idle;
    logic  ack;
    int    idx;
    int    cyc;
    logic  v;
    logic  rdy;
    logic  rs;
    logic [TW-1:0] expTid[5];

    idle = '0;
    applyStimulus(1'b0, idle, 1'b0, 1'b1);
    @(posedge clk);
    #1;

    // Reset then idle: buffer must come up empty.
    doCycle(1'b1, idle, 1'b0, 1'b1, ack);
    doCycle(1'b0, idle, 1'b0, 1'b1, ack);
    doCycle(1'b0, idle, 1'b0, 1'b0, ack);
    checkEq("reset_val", lastVal, 1'b0);
    checkEq("reset_count", lastCount, 0);

    // Single response, consumer always ready.
    r = randResp();
    r.rt = 4'h0;
    r.data = {16{32'hA5A5A5A5}};
    doCycle(1'b1, r, 1'b1, 1'b0, ack);
    checkEq("single_ack_c0", lastAck, 1'b1);
    doCycle(1'b0, idle, 1'b1, 1'b0, ack);
    checkEq("single_val_c1", lastVal, 1'b1);
    checkEq("single_data_c1", lastData, {16{32'hA5A5A5A5}});
    doCycle(1'b0, idle, 1'b1, 1'b0, ack);
    checkEq("single_count_c2", lastCount, 0);

    // Fill and stall with alternating thread ids.
    tidLog.delete();
    for (int i = 0; i < 4; i++) begin
      r = randResp();
      r.tid = i[TW-1:0];
      doCycle(1'b1, r, 1'b0, 1'b0, ack);
      checkEq("fill_ack", lastAck, 1'b1);
    end
    r = randResp();
    r.tid = '0;
    doCycle(1'b1, r, 1'b0, 1'b0, ack);
    checkEq("full_ack_held", lastAck, 1'b0);
    checkEq("full_count", lastCount, 4);
    doCycle(1'b1, r, 1'b1, 1'b0, ack);
    checkEq("full_pop_no_ack", lastAck, 1'b0);
    doCycle(1'b1, r, 1'b0, 1'b0, ack);
    checkEq("fifth_acked", lastAck, 1'b1);
    for (int i = 0; i < 6; i++) doCycle(1'b0, idle, 1'b1, 1'b0, ack);
    expTid = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    checkEq("tid_log_size", tidLog.size(), 5);
    for (int i = 0; i < 5 && i < tidLog.size(); i++) checkEq("tid_order", tidLog[i], expTid[i]);

    // Wrap-around: ten indexed responses, consumer ready every other cycle.
    dataLog.delete();
    idx = 0;
    cyc = 0;
    r = randResp();
    r.data = '0;
    while ((idx < 10 || q.size() > 0) && cyc < 200) begin
      v = (idx < 10);
      doCycle(v, r, (cyc % 2 == 0), 1'b0, ack);
      if (v && ack) begin
        idx++;
        r = randResp();
        r.data = '0;
        r.data[31:0] = idx;
      end
      cyc++;
    end
    checkEq("wrap_timeout", cyc < 200, 1'b1);
    checkEq("wrap_log_size", dataLog.size(), 10);
    for (int i = 0; i < 10 && i < dataLog.size(); i++) checkEq("wrap_order", dataLog[i], i);

    // Simultaneous push and pop at occupancy two.
    r = randResp(); r.data = 100;
    doCycle(1'b1, r, 1'b0, 1'b0, ack);
    r = randResp(); r.data = 101;
    doCycle(1'b1, r, 1'b0, 1'b0, ack);
    r = randResp(); r.data = 102;
    doCycle(1'b1, r, 1'b1, 1'b0, ack);
    checkEq("pp_ack", lastAck, 1'b1);
    checkEq("pp_count_before", lastCount, 2);
    doCycle(1'b0, idle, 1'b0, 1'b0, ack);
    checkEq("pp_count_after", lastCount, 2);
    checkEq("pp_head", lastData, 101);
    for (int i = 0; i < 3; i++) doCycle(1'b0, idle, 1'b1, 1'b0, ack);

    // Reset with three buffered responses.
    for (int i = 0; i < 3; i++) begin
      r = randResp();
      doCycle(1'b1, r, 1'b0, 1'b0, ack);
    end
    doCycle(1'b0, idle, 1'b0, 1'b1, ack);
    checkEq("midrst_ack", lastAck, 1'b0);
    doCycle(1'b0, idle, 1'b0, 1'b0, ack);
    checkEq("midrst_val", lastVal, 1'b0);
    checkEq("midrst_count", lastCount, 0);
    r = randResp(); r.data = 32'hBEEF;
    doCycle(1'b1, r, 1'b0, 1'b0, ack);
    doCycle(1'b0, idle, 1'b1, 1'b0, ack);
    checkEq("midrst_fresh_head", lastData, 32'hBEEF);
    checkEq("midrst_fresh_count", lastCount, 1);
    doCycle(1'b0, idle, 1'b1, 1'b0, ack);

    // Randomized traffic; a response is held until acknowledged.
    r = randResp();
    for (int i = 0; i < 400; i++) begin
      v   = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      rs  = ($urandom_range(0, 99) == 0);
      doCycle(v, r, rdy, rs, ack);
      if (ack) r = randResp();
    end
    for (int i = 0; i < 6; i++) doCycle(1'b0, idle, 1'b1, 1'b0, ack);
    checkEq("random_drained", lastCount, 0);

`ifdef L15_RESP_BUFFER_STATS_EN
    // Stall and high-water statistics.
    doCycle(1'b0, idle, 1'b0, 1'b1, ack);
    for (int i = 0; i < 4; i++) begin
      r = randResp();
      doCycle(1'b1, r, 1'b0, 1'b0, ack);
    end
    r = randResp();
    for (int i = 0; i < 7; i++) doCycle(1'b1, r, 1'b0, 1'b0, ack);
    doCycle(1'b0, idle, 1'b0, 1'b0, ack);
    checkEq("stats_stall7", lastStall, 7);
    checkEq("stats_max4", lastMax, 4);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
